// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: op codes, access sizes and FSM states.
package mem_pkg;

   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
   localparam logic [1:0] MEM_OP_STORE = 2'b10;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } mem_state_t;

endpackage

// File: rtl/load_aligner.sv
// Shifts raw load data down to lane 0 and sign/zero-extends it to 32 bits.
module load_aligner
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   output logic [31:0] data
);

   logic [1:0]  lane;
   logic [31:0] shifted;

   always_comb begin
      lane = 2'b00;
      case (size)
         MEM_SIZE_BYTE: lane = offset;
         MEM_SIZE_HALF: lane = {offset[1], 1'b0};
         default:       lane = 2'b00;
      endcase
   end

   assign shifted = rdata >> {lane, 3'b000};

   always_comb begin
      data = shifted;
      case (size)
         MEM_SIZE_BYTE: data = load_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
         MEM_SIZE_HALF: data = load_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
         default:       data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory requests and aligns load results for writeback.
// Define MEM_STAGE_MISALIGN_TRAP_EN to suppress misaligned accesses and pulse `misaligned`.
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              valid,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       storeData,
   input  logic [1:0]        memOp,
   input  logic [1:0]        memSize,
   input  logic              loadUnsigned,
   input  logic [4:0]        rdIn,
   input  logic              regWriteIn,
   output logic              hold,
   output logic              dmemReq,
   output logic              dmemWe,
   output logic [ADDR_W-1:0] dmemAddr,
   output logic [31:0]       dmemWdata,
   output logic [3:0]        dmemBe,
   input  logic [31:0]       dmemRdata,
   input  logic              dmemAck,
   output logic              wbValid,
   output logic [4:0]        wbRd,
   output logic              wbWrite,
   output logic [31:0]       wbData,
   output logic              misaligned,
   output mem_state_t        state_dbg
);

   mem_state_t state;
   logic [1:0] off_q;
   logic [1:0] size_q;
   logic       uns_q;
   logic [4:0] rd_q;
   logic       write_q;

   logic        is_mem;
   logic        is_store;
   logic        trap;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] load_data;

   assign is_mem   = (memOp == MEM_OP_LOAD) || (memOp == MEM_OP_STORE);
   assign is_store = (memOp == MEM_OP_STORE);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic misaligned_q;
   assign trap = (memSize == MEM_SIZE_HALF) ? addr[0]
               : (memSize == MEM_SIZE_BYTE) ? 1'b0
               : (addr[1:0] != 2'b00);
   assign misaligned = misaligned_q;
`else
   assign trap       = 1'b0;
   assign misaligned = 1'b0;
`endif

   always_comb begin
      be    = 4'b1111;
      wdata = storeData;
      case (memSize)
         MEM_SIZE_BYTE: begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{storeData[7:0]}};
         end
         MEM_SIZE_HALF: begin
            be    = 4'b0011 << {addr[1], 1'b0};
            wdata = {2{storeData[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = storeData;
         end
      endcase
   end

   load_aligner u_load_aligner (
      .rdata        (dmemRdata),
      .offset       (off_q),
      .size         (size_q),
      .load_unsigned(uns_q),
      .data         (load_data)
   );

   assign hold      = (state == S_ACCESS);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= S_IDLE;
         dmemReq   <= 1'b0;
         dmemWe    <= 1'b0;
         dmemAddr  <= '0;
         dmemWdata <= '0;
         dmemBe    <= '0;
         wbValid   <= 1'b0;
         wbRd      <= '0;
         wbWrite   <= 1'b0;
         wbData    <= '0;
         off_q     <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         rd_q      <= '0;
         write_q   <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         wbValid <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (valid && !is_mem) begin
                  wbValid <= 1'b1;
                  wbData  <= 32'(addr);
                  wbRd    <= rdIn;
                  wbWrite <= regWriteIn;
               end else if (valid && trap) begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                  misaligned_q <= 1'b1;
`endif
               end else if (valid) begin
                  state     <= S_ACCESS;
                  dmemReq   <= 1'b1;
                  dmemWe    <= is_store;
                  dmemAddr  <= {addr[ADDR_W-1:2], 2'b00};
                  dmemWdata <= wdata;
                  dmemBe    <= be;
                  off_q     <= addr[1:0];
                  size_q    <= memSize;
                  uns_q     <= loadUnsigned;
                  rd_q      <= rdIn;
                  write_q   <= regWriteIn & ~is_store;
               end
            end
            S_ACCESS: begin
               // Request fields stay frozen until the memory acknowledges.
               if (dmemAck) begin
                  state   <= S_IDLE;
                  dmemReq <= 1'b0;
                  wbValid <= 1'b1;
                  wbRd    <= rd_q;
                  wbWrite <= write_q;
                  if (!dmemWe) wbData <= load_data;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed vector bench for mem_stage: table of single transactions plus hand sequences.
module tb_mem_stage;
   import mem_pkg::*;

   logic        clk;
   logic        rstN;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] storeData;
   logic [1:0]  memOp;
   logic [1:0]  memSize;
   logic        loadUnsigned;
   logic [4:0]  rdIn;
   logic        regWriteIn;
   logic        hold;
   logic        dmemReq;
   logic        dmemWe;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;
   logic [3:0]  dmemBe;
   logic [31:0] dmemRdata;
   logic        dmemAck;
   logic        wbValid;
   logic [4:0]  wbRd;
   logic        wbWrite;
   logic [31:0] wbData;
   logic        misaligned;
   mem_state_t  state_dbg;

   int n_total;
   int n_pass;

   mem_stage #(.ADDR_W(32)) dut (
      .clk(clk), .rstN(rstN), .valid(valid), .addr(addr), .storeData(storeData),
      .memOp(memOp), .memSize(memSize), .loadUnsigned(loadUnsigned), .rdIn(rdIn),
      .regWriteIn(regWriteIn), .hold(hold), .dmemReq(dmemReq), .dmemWe(dmemWe),
      .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemBe(dmemBe),
      .dmemRdata(dmemRdata), .dmemAck(dmemAck), .wbValid(wbValid), .wbRd(wbRd),
      .wbWrite(wbWrite), .wbData(wbData), .misaligned(misaligned),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] a;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] wdata;
      logic [31:0] wb;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic add_vec(input logic [1:0] op, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [3:0] be,
                          input logic [31:0] maddr, input logic [31:0] wdata,
                          input logic [31:0] wb);
      vec_t v;
      v.op = op; v.size = size; v.uns = uns; v.a = a; v.sdata = sdata;
      v.rdata = rdata; v.be = be; v.maddr = maddr; v.wdata = wdata; v.wb = wb;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic regw);
      valid = 1'b1; memOp = op; memSize = size; loadUnsigned = uns;
      addr = a; storeData = sdata; rdIn = rd; regWriteIn = regw;
   endtask

   task automatic idle_inputs();
      valid = 1'b0; memOp = 2'b00; memSize = 2'b00; loadUnsigned = 1'b0;
      addr = '0; storeData = '0; rdIn = '0; regWriteIn = 1'b0;
   endtask

   initial begin
      logic        regw;
      logic [4:0]  rd;
      logic        is_mem;
      n_total = 0;
      n_pass  = 0;
      idle_inputs();
      dmemRdata = '0;
      dmemAck   = 1'b0;
      rstN      = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_hold",     {31'h0, hold},       32'h0);
      check("rst_req",      {31'h0, dmemReq},    32'h0);
      check("rst_we",       {31'h0, dmemWe},     32'h0);
      check("rst_wbvalid",  {31'h0, wbValid},    32'h0);
      check("rst_wbwrite",  {31'h0, wbWrite},    32'h0);
      check("rst_misalign", {31'h0, misaligned}, 32'h0);
      check("rst_be",       {28'h0, dmemBe},     32'h0);
      check("rst_addr",     dmemAddr,            32'h0);
      check("rst_wdata",    dmemWdata,           32'h0);
      check("rst_wbdata",   wbData,              32'h0);
      check("rst_wbrd",     {27'h0, wbRd},       32'h0);
      check("rst_state",    {31'h0, state_dbg == S_IDLE}, 32'h1);
      rstN = 1'b1;
      @(negedge clk);

      //        op     size   uns  addr          sdata         rdata         be       maddr         wdata         wb
      add_vec(2'b00, 2'b00, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'h0000_1234);
      add_vec(2'b01, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 4'b1000, 32'h0000_0100, 32'h0,      32'hFFFF_FF80);
      add_vec(2'b01, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'hBEEF_0000, 4'b1100, 32'h0000_0100, 32'h0,      32'h0000_BEEF);
      add_vec(2'b10, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_56AB, 32'h0,       4'b0010, 32'h0000_0200, 32'hABAB_ABAB, 32'h0);
      add_vec(2'b10, 2'b01, 1'b0, 32'h0000_0302, 32'h1234_5678, 32'h0,       4'b1100, 32'h0000_0300, 32'h5678_5678, 32'h0);
      add_vec(2'b10, 2'b10, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0,       4'b1111, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0);
      add_vec(2'b01, 2'b10, 1'b0, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 4'b1111, 32'h0000_0104, 32'h0,      32'hCAFE_F00D);
      add_vec(2'b01, 2'b01, 1'b0, 32'h0000_0100, 32'h0,        32'h1234_8001, 4'b0011, 32'h0000_0100, 32'h0,      32'hFFFF_8001);
      add_vec(2'b01, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        32'h0000_F000, 4'b0010, 32'h0000_0100, 32'h0,      32'h0000_00F0);
      add_vec(2'b11, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'hFFFF_FFFF);
      add_vec(2'b01, 2'b11, 1'b0, 32'h0000_0108, 32'h0,        32'h1122_3344, 4'b1111, 32'h0000_0108, 32'h0,      32'h1122_3344);
      add_vec(2'b01, 2'b00, 1'b0, 32'h0000_0102, 32'h0,        32'h0012_0000, 4'b0100, 32'h0000_0100, 32'h0,      32'h0000_0012);
`ifndef MEM_STAGE_MISALIGN_TRAP_EN
      add_vec(2'b01, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'h89AB_CDEF, 4'b1111, 32'h0000_0100, 32'h0,      32'h89AB_CDEF);
      add_vec(2'b01, 2'b01, 1'b1, 32'h0000_0103, 32'h0,        32'hBEEF_0000, 4'b1100, 32'h0000_0100, 32'h0,      32'h0000_BEEF);
`endif

      // each transaction starts the cycle after the previous writeback
      foreach (vecs[i]) begin
         regw   = (i % 3) != 0;
         rd     = 5'(i + 1);
         is_mem = (vecs[i].op == 2'b01) || (vecs[i].op == 2'b10);
         drive(vecs[i].op, vecs[i].size, vecs[i].uns, vecs[i].a, vecs[i].sdata, rd, regw);
         @(negedge clk);
         idle_inputs();
         if (is_mem) begin
            check($sformatf("v%0d_req", i),   {31'h0, dmemReq}, 32'h1);
            check($sformatf("v%0d_hold", i),  {31'h0, hold},    32'h1);
            check($sformatf("v%0d_we", i),    {31'h0, dmemWe},  {31'h0, vecs[i].op == 2'b10});
            check($sformatf("v%0d_be", i),    {28'h0, dmemBe},  {28'h0, vecs[i].be});
            check($sformatf("v%0d_maddr", i), dmemAddr,         vecs[i].maddr);
            if (vecs[i].op == 2'b10)
               check($sformatf("v%0d_wdata", i), dmemWdata, vecs[i].wdata);
            check($sformatf("v%0d_early_wb", i), {31'h0, wbValid}, 32'h0);
            dmemAck   = 1'b1;
            dmemRdata = vecs[i].rdata;
            @(negedge clk);
            dmemAck   = 1'b0;
            dmemRdata = 32'h5A5A_5A5A;
            check($sformatf("v%0d_req_drop", i), {31'h0, dmemReq}, 32'h0);
            check($sformatf("v%0d_hold_drop", i), {31'h0, hold},   32'h0);
         end else begin
            check($sformatf("v%0d_req", i),  {31'h0, dmemReq}, 32'h0);
            check($sformatf("v%0d_hold", i), {31'h0, hold},    32'h0);
         end
         check($sformatf("v%0d_wbvalid", i), {31'h0, wbValid}, 32'h1);
         check($sformatf("v%0d_wbrd", i),    {27'h0, wbRd},    {27'h0, rd});
         check($sformatf("v%0d_wbwrite", i), {31'h0, wbWrite},
               {31'h0, regw && (vecs[i].op != 2'b10)});
         if (vecs[i].op != 2'b10)
            check($sformatf("v%0d_wbdata", i), wbData, vecs[i].wb);
      end

      // writeback is a single-cycle pulse
      @(negedge clk);
      check("wb_pulse_end", {31'h0, wbValid}, 32'h0);

      // ack while idle is ignored
      dmemAck = 1'b1;
      @(negedge clk);
      dmemAck = 1'b0;
      check("idle_ack_wb",   {31'h0, wbValid}, 32'h0);
      check("idle_ack_hold", {31'h0, hold},    32'h0);

      // signed byte load with ack three cycles after the request: hold lasts 4 cycles
      drive(2'b01, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd9, 1'b1);
      @(negedge clk);
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("slow_hold%0d", k), {31'h0, hold},    32'h1);
         check($sformatf("slow_req%0d", k),  {31'h0, dmemReq}, 32'h1);
         check($sformatf("slow_wb%0d", k),   {31'h0, wbValid}, 32'h0);
         check($sformatf("slow_be%0d", k),   {28'h0, dmemBe},  32'h8);
         if (k == 3) begin
            dmemAck   = 1'b1;
            dmemRdata = 32'h80FF_FFFF;
         end
         @(negedge clk);
      end
      dmemAck = 1'b0;
      check("slow_wbvalid", {31'h0, wbValid}, 32'h1);
      check("slow_wbdata",  wbData,           32'hFFFF_FF80);
      check("slow_hold_off", {31'h0, hold},   32'h0);

      // reset in the middle of an access abandons it
      drive(2'b01, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      idle_inputs();
      check("abort_req_before", {31'h0, dmemReq}, 32'h1);
      #2 rstN = 1'b0;
      #1;
      check("abort_req",  {31'h0, dmemReq}, 32'h0);
      check("abort_hold", {31'h0, hold},    32'h0);
      dmemAck   = 1'b1;
      dmemRdata = 32'h1357_9BDF;
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      dmemAck = 1'b0;
      check("abort_no_wb",   {31'h0, wbValid}, 32'h0);
      check("abort_no_hold", {31'h0, hold},    32'h0);
      check("abort_wbdata",  wbData,           32'h0);

      // misaligned word load
      drive(2'b01, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 5'd4, 1'b1);
      @(negedge clk);
      idle_inputs();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      check("mis_pulse", {31'h0, misaligned}, 32'h1);
      check("mis_req",   {31'h0, dmemReq},    32'h0);
      check("mis_hold",  {31'h0, hold},       32'h0);
      check("mis_wb",    {31'h0, wbValid},    32'h0);
      @(negedge clk);
      check("mis_pulse_end", {31'h0, misaligned}, 32'h0);
      check("mis_wb_after",  {31'h0, wbValid},    32'h0);
`else
      check("mis_none",  {31'h0, misaligned}, 32'h0);
      check("mis_req",   {31'h0, dmemReq},    32'h1);
      check("mis_be",    {28'h0, dmemBe},     32'hF);
      check("mis_maddr", dmemAddr,            32'h0000_0100);
      dmemAck   = 1'b1;
      dmemRdata = 32'h0BAD_F00D;
      @(negedge clk);
      dmemAck = 1'b0;
      check("mis_wbdata", wbData, 32'h0BAD_F00D);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
